v_lane_sequencer: RTL and testbench

- Parametrised lane-group sequencer for the vector coprocessor.
- Takes an LMUL register group (1, 2 or 4 chunks of GROUP_W bits per operand) and a runtime count of active lane groups (1, 2 or 4).
- Issues chunks to the external ALU/MUL lane array over one or more steps, collects lane results into a full-width result and signals completion.
- Per-group enables replace per-lane gated clocks; the design is single-clock.

---
 rtl/v_lane_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_v_lane_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_lane_sequencer.sv
// Lane-group sequencer: issues LMUL register-group chunks to the lane array in one or more steps
// and assembles lane results. Optional perf counters are enabled by `define V_LANE_SEQ_PERF_CNT_EN.
module v_lane_sequencer #(
  parameter int unsigned GROUP_W    = 128,
  parameter int unsigned MAX_GROUPS = 4,
  parameter int unsigned MAX_LMUL   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    lmul,
  input  logic [1:0]                    lanes,
  input  logic [MAX_LMUL*GROUP_W-1:0]   op_a_i,
  input  logic [MAX_LMUL*GROUP_W-1:0]   op_b_i,
  output logic                          issue_valid,
  output logic [MAX_GROUPS-1:0]         issue_en,
  output logic [MAX_GROUPS*GROUP_W-1:0] issue_a,
  output logic [MAX_GROUPS*GROUP_W-1:0] issue_b,
  input  logic                          res_valid,
  input  logic [MAX_GROUPS*GROUP_W-1:0] res_data,
  output logic [MAX_LMUL*GROUP_W-1:0]   result_o,
  output logic                          busy,
  output logic                          done,
  output logic                          err
`ifdef V_LANE_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]              perf_cycles,
  output logic [2:0]                    perf_steps
`endif
);

  if (MAX_GROUPS != 4 || MAX_LMUL != 4 || CNT_W == 0) begin : g_bad_params
    $error("v_lane_sequencer: MAX_GROUPS and MAX_LMUL must be 4, CNT_W must be nonzero");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_e;

  state_e             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [1:0]         lc_q, lc_d, lg_q, lg_d;   // log2 of chunk count / group count
  logic               err_pend_q, err_pend_d;
  logic [GROUP_W-1:0] op_a_q [MAX_LMUL];
  logic [GROUP_W-1:0] op_a_d [MAX_LMUL];
  logic [GROUP_W-1:0] op_b_q [MAX_LMUL];
  logic [GROUP_W-1:0] op_b_d [MAX_LMUL];

  logic                  issue_valid_q, issue_valid_d;
  logic [MAX_GROUPS-1:0] issue_en_q, issue_en_d;
  logic [GROUP_W-1:0]    issue_a_q [MAX_GROUPS];
  logic [GROUP_W-1:0]    issue_a_d [MAX_GROUPS];
  logic [GROUP_W-1:0]    issue_b_q [MAX_GROUPS];
  logic [GROUP_W-1:0]    issue_b_d [MAX_GROUPS];
  logic [GROUP_W-1:0]    result_q  [MAX_LMUL];
  logic [GROUP_W-1:0]    result_d  [MAX_LMUL];
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [MAX_GROUPS-1:0] iss_en, cap_en;
  logic [3:0]            iss_base, cap_base;

  // Groups used per step is min(C, G); steps needed is max(1, C/G).
  function automatic logic [MAX_GROUPS-1:0] used_mask(input logic [1:0] lc, input logic [1:0] lg);
    logic [1:0] ul;
    ul = (lc < lg) ? lc : lg;
    case (ul)
      2'd0:    return MAX_GROUPS'(4'b0001);
      2'd1:    return MAX_GROUPS'(4'b0011);
      default: return MAX_GROUPS'(4'b1111);
    endcase
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] lc, input logic [1:0] lg);
    if (lc > lg) return ((lc - lg) == 2'd2) ? 2'd3 : 2'd1;
    return 2'd0;
  endfunction

  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      state_q       <= S_IDLE;
      step_q        <= 2'd0;
      lc_q          <= 2'd0;
      lg_q          <= 2'd0;
      err_pend_q    <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_en_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      for (int k = 0; k < MAX_LMUL; k++) begin
        op_a_q[k]   <= '0;
        op_b_q[k]   <= '0;
        result_q[k] <= '0;
      end
      for (int g = 0; g < MAX_GROUPS; g++) begin
        issue_a_q[g] <= '0;
        issue_b_q[g] <= '0;
      end
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      lc_q          <= lc_d;
      lg_q          <= lg_d;
      err_pend_q    <= err_pend_d;
      issue_valid_q <= issue_valid_d;
      issue_en_q    <= issue_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      result_q      <= result_d;
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
    end
  end

  always_comb begin : p_next
    state_d    = state_q;
    step_d     = step_q;
    lc_d       = lc_q;
    lg_d       = lg_q;
    err_pend_d = err_pend_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < MAX_LMUL; k++) begin
            op_a_d[k] = op_a_i[k*GROUP_W +: GROUP_W];
            op_b_d[k] = op_b_i[k*GROUP_W +: GROUP_W];
          end
          lc_d       = lmul;
          lg_d       = lanes;
          step_d     = 2'd0;
          err_pend_d = (lmul == 2'b11) || (lanes == 2'b11);
          state_d    = err_pend_d ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (res_valid) begin
          if (step_q == last_step(lc_q, lg_q)) begin
            state_d = S_FIN;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        state_d    = S_IDLE;
        step_d     = 2'd0;
        err_pend_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin : p_out
    issue_valid_d = (state_d == S_ISSUE);
    busy_d        = (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d        = (state_d == S_FIN);
    err_d         = (state_d == S_FIN) && err_pend_d;
    issue_en_d    = issue_en_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    result_d      = result_q;
    iss_en        = used_mask(lc_d, lg_d);
    iss_base      = 4'(step_d) << lg_d;
    cap_en        = used_mask(lc_q, lg_q);
    cap_base      = 4'(step_q) << lg_q;

    if (state_d == S_ISSUE) begin
      issue_en_d = iss_en;
      for (int g = 0; g < MAX_GROUPS; g++) begin
        issue_a_d[g] = iss_en[g] ? op_a_d[2'(iss_base + 4'(g))] : '0;
        issue_b_d[g] = iss_en[g] ? op_b_d[2'(iss_base + 4'(g))] : '0;
      end
    end else if (state_d != S_WAIT) begin
      issue_en_d = '0;
      for (int g = 0; g < MAX_GROUPS; g++) begin
        issue_a_d[g] = '0;
        issue_b_d[g] = '0;
      end
    end

    if (state_q == S_IDLE && start) begin
      for (int k = 0; k < MAX_LMUL; k++) result_d[k] = '0;
    end else if (state_q == S_WAIT && res_valid) begin
      for (int g = 0; g < MAX_GROUPS; g++) begin
        if (cap_en[g]) result_d[2'(cap_base + 4'(g))] = res_data[g*GROUP_W +: GROUP_W];
      end
    end
  end

  for (genvar g = 0; g < MAX_GROUPS; g++) begin : g_issue_flat
    assign issue_a[g*GROUP_W +: GROUP_W] = issue_a_q[g];
    assign issue_b[g*GROUP_W +: GROUP_W] = issue_b_q[g];
  end
  for (genvar k = 0; k < MAX_LMUL; k++) begin : g_result_flat
    assign result_o[k*GROUP_W +: GROUP_W] = result_q[k];
  end

  assign issue_valid = issue_valid_q;
  assign issue_en    = issue_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

`ifdef V_LANE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cycles_q, perf_cycles_d;
  logic [2:0]       perf_steps_q, perf_steps_d;

  always_comb begin : p_perf_next
    perf_cycles_d = perf_cycles_q;
    perf_steps_d  = perf_steps_q;
    if (state_q == S_IDLE && start) begin
      perf_cycles_d = '0;
      perf_steps_d  = 3'd0;
    end else begin
      if (busy_q && !(&perf_cycles_q)) perf_cycles_d = perf_cycles_q + CNT_W'(1);
      if (state_q == S_ISSUE)          perf_steps_d  = perf_steps_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin : p_perf_state
    if (rst) begin
      perf_cycles_q <= '0;
      perf_steps_q  <= 3'd0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_steps_q  <= perf_steps_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_steps  = perf_steps_q;
`else
`endif

endmodule

// File: tb/tb_v_lane_sequencer.sv
// Bench for v_lane_sequencer: vector table of LMUL/lane configurations, scoreboard of expected
// issues and results, lane model with configurable latency, plus reset and start-spam sequences.
module tb_v_lane_sequencer;
  localparam int unsigned GW = 128;
  localparam int unsigned NG = 4;
  localparam int unsigned NL = 4;
  localparam int unsigned WD = NL*GW;

  logic          clk = 1'b0;
  logic          rst, start, res_valid;
  logic [1:0]    lmul, lanes;
  logic [WD-1:0] op_a_i, op_b_i, res_data, issue_a, issue_b, result_o;
  logic          issue_valid, busy, done, err;
  logic [NG-1:0] issue_en;

  always #5 clk = ~clk;

  v_lane_sequencer #(.GROUP_W(GW), .MAX_GROUPS(NG), .MAX_LMUL(NL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .lmul(lmul), .lanes(lanes),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .issue_valid(issue_valid), .issue_en(issue_en),
    .issue_a(issue_a), .issue_b(issue_b), .res_valid(res_valid), .res_data(res_data),
    .result_o(result_o), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [1:0] lmul;
    logic [1:0] lanes;
    int         lat;
    int         exp_done;
    logic       exp_err;
    logic       spam;
  } vec_t;

  typedef struct {
    logic [NG-1:0] en;
    logic [WD-1:0] a;
    logic [WD-1:0] b;
  } iss_t;

  iss_t          q_iss[$];
  logic [WD-1:0] q_res[$];
  int            checks = 0, failures = 0;
  int            cyc, cur_lat, lane_due, n_issue;
  bit            lane_pend;
  logic [WD-1:0] lane_data;
  vec_t          vecs[10];

  task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WD-1:0] rnd_wide();
    logic [WD-1:0] v;
    for (int i = 0; i < int'(WD/32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected issue sequence and final result for one operation; returns the step count.
  task automatic push_expected(input logic [1:0] lm, input logic [1:0] ln,
                               input logic [WD-1:0] opa, input logic [WD-1:0] opb,
                               output int steps);
    int c, g_n, s_n, u_n, k;
    iss_t e;
    logic [WD-1:0] r;
    steps = 0;
    if (lm == 2'b11 || ln == 2'b11) begin
      q_res.push_back('0);
      return;
    end
    c   = 1 << lm;
    g_n = 1 << ln;
    s_n = (c > g_n) ? c / g_n : 1;
    u_n = (c < g_n) ? c : g_n;
    for (int s = 0; s < s_n; s++) begin
      e.en = NG'((1 << u_n) - 1);
      e.a  = '0;
      e.b  = '0;
      for (int g = 0; g < u_n; g++) begin
        k = s * g_n + g;
        e.a[g*GW +: GW] = opa[k*GW +: GW];
        e.b[g*GW +: GW] = opb[k*GW +: GW];
      end
      q_iss.push_back(e);
    end
    r = '0;
    for (int kk = 0; kk < c; kk++) r[kk*GW +: GW] = opa[kk*GW +: GW];
    q_res.push_back(r);
    steps = s_n;
  endtask

  // One clock: check any issue against the scoreboard, then drive the lane model for this cycle.
  task automatic cycle_step();
    iss_t e;
    tick();
    cyc++;
    if (issue_valid === 1'b1) begin
      n_issue++;
      if (q_iss.size() == 0) begin
        check("issue_unexpected", WD'(issue_valid), '0);
      end else begin
        e = q_iss.pop_front();
        check("issue_en", WD'(issue_en), WD'(e.en));
        check("issue_a", issue_a, e.a);
        check("issue_b", issue_b, e.b);
      end
      lane_pend = 1'b1;
      lane_due  = cyc + cur_lat;
      lane_data = issue_a;
    end
    if (lane_pend && lane_due == cyc) begin
      res_valid = 1'b1;
      res_data  = lane_data;
      lane_pend = 1'b0;
    end else begin
      res_valid = 1'b0;
      res_data  = rnd_wide();
    end
  endtask

  task automatic run_op(input vec_t v);
    int            exp_steps;
    bit            got_done;
    logic [WD-1:0] exp_r, opa, opb;
    tick();
    q_iss.delete();
    q_res.delete();
    opa = rnd_wide();
    opb = rnd_wide();
    start = 1'b1; lmul = v.lmul; lanes = v.lanes; op_a_i = opa; op_b_i = opb;
    push_expected(v.lmul, v.lanes, opa, opb, exp_steps);
    cur_lat = v.lat; cyc = 0; n_issue = 0; lane_pend = 1'b0; got_done = 1'b0;
    while (!got_done && cyc < 64) begin
      cycle_step();
      if (done === 1'b1) got_done = 1'b1;
      start = v.spam && (got_done || (cyc % 2 == 1));
      if (start) begin
        op_a_i = rnd_wide();
        op_b_i = rnd_wide();
        lmul   = 2'($urandom);
        lanes  = 2'($urandom);
      end
      if (cyc == 1) check("busy_cycle1", WD'(busy), WD'(!v.exp_err));
    end
    exp_r = q_res.pop_front();
    if (!got_done) begin
      checks++;
      failures++;
      $display("FAIL timeout: done=%0b after %0d cycles, expected done at cycle %0d", done, cyc, v.exp_done);
      start = 1'b0;
      return;
    end
    check("done_cycle", WD'(cyc), WD'(v.exp_done));
    check("err", WD'(err), WD'(v.exp_err));
    check("busy_at_done", WD'(busy), '0);
    check("issue_en_at_done", WD'(issue_en), '0);
    check("result", result_o, exp_r);
    check("issue_count", WD'(n_issue), WD'(exp_steps));
    if (v.spam) begin
      cycle_step();
      start = 1'b0;
      check("no_second_done", WD'(done), '0);
      cycle_step();
      check("idle_busy", WD'(busy), '0);
      check("result_held", result_o, exp_r);
    end
  endtask

  initial begin
    vec_t          rv;
    logic [WD-1:0] opa, opb, part;
    int            steps;

    vecs[0] = '{lmul: 2'b00, lanes: 2'b00, lat: 1, exp_done: 3,  exp_err: 1'b0, spam: 1'b0};
    vecs[1] = '{lmul: 2'b10, lanes: 2'b00, lat: 2, exp_done: 13, exp_err: 1'b0, spam: 1'b0};
    vecs[2] = '{lmul: 2'b10, lanes: 2'b01, lat: 1, exp_done: 5,  exp_err: 1'b0, spam: 1'b0};
    vecs[3] = '{lmul: 2'b01, lanes: 2'b10, lat: 1, exp_done: 3,  exp_err: 1'b0, spam: 1'b0};
    vecs[4] = '{lmul: 2'b11, lanes: 2'b00, lat: 1, exp_done: 1,  exp_err: 1'b1, spam: 1'b1};
    vecs[5] = '{lmul: 2'b00, lanes: 2'b11, lat: 1, exp_done: 1,  exp_err: 1'b1, spam: 1'b0};
    vecs[6] = '{lmul: 2'b10, lanes: 2'b10, lat: 3, exp_done: 5,  exp_err: 1'b0, spam: 1'b0};
    vecs[7] = '{lmul: 2'b01, lanes: 2'b00, lat: 2, exp_done: 7,  exp_err: 1'b0, spam: 1'b0};
    vecs[8] = '{lmul: 2'b01, lanes: 2'b01, lat: 1, exp_done: 3,  exp_err: 1'b0, spam: 1'b1};
    vecs[9] = '{lmul: 2'b00, lanes: 2'b10, lat: 4, exp_done: 6,  exp_err: 1'b0, spam: 1'b0};

    rst = 1'b1; start = 1'b0; lmul = 2'b00; lanes = 2'b00;
    op_a_i = '0; op_b_i = '0; res_valid = 1'b0; res_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_issue_valid", WD'(issue_valid), '0);
    check("rst_issue_en", WD'(issue_en), '0);
    check("rst_issue_a", issue_a, '0);
    check("rst_issue_b", issue_b, '0);
    check("rst_result", result_o, '0);
    check("rst_busy_done_err", WD'({busy, done, err}), '0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Reset during the WAIT of step 1 of a four-step operation.
    tick();
    q_iss.delete();
    q_res.delete();
    opa = rnd_wide();
    opb = rnd_wide();
    start = 1'b1; lmul = 2'b10; lanes = 2'b00; op_a_i = opa; op_b_i = opb;
    push_expected(2'b10, 2'b00, opa, opb, steps);
    cur_lat = 2; cyc = 0; n_issue = 0; lane_pend = 1'b0;
    while (n_issue < 2 && cyc < 40) begin
      cycle_step();
      start = 1'b0;
    end
    check("rst_seq_reached_step1", WD'(n_issue), WD'(2));
    cycle_step();
    part = '0;
    part[0 +: GW] = opa[0 +: GW];
    check("partial_result", result_o, part);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", WD'(busy), '0);
    check("midrst_done", WD'(done), '0);
    check("midrst_issue", WD'({issue_valid, issue_en}), '0);
    check("midrst_result", result_o, '0);
    res_valid = 1'b1;
    res_data  = lane_data;
    tick();
    res_valid = 1'b0;
    check("late_res_result", result_o, '0);
    check("late_res_done", WD'({busy, done}), '0);

    rv = '{lmul: 2'b10, lanes: 2'b01, lat: 2, exp_done: 7, exp_err: 1'b0, spam: 1'b0};
    run_op(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
